mul_div_unit: RTL and testbench

- Iterative 16-bit unsigned multiply/divide execute stage, directly downstream of the 8x16 register file read ports.
- Consumes Reg_RData1/Reg_RData2 as operands.
- Writes its result back through the register file write port (REG_W_ID, Reg_WE, Reg_WData).
- Lets the single-clock CPU support MUL/MULH/DIV/REM without a combinational 16x16 array.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_datapath.sv | 59 +++++
 rtl/mul_div_unit.sv | 132 +++++++++++++
 tb/tb_mul_div_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WB   = 2'b10
  } state_e;

  // Quotient written on divide-by-zero; sliced down to the unit width.
  localparam int              MAX_W     = 64;
  localparam logic [MAX_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mdu_datapath.sv
// Accumulator and single-step shift/add (MUL) or restoring-subtract (DIV) datapath.
module mdu_datapath #(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] acc_nxt_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               div_q, div_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_nxt;

  // MUL: acc = {hi, multiplier}; DIV: acc = {rem, quot}, quot starts as dividend.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    trial   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
    div_nxt = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                           : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    acc_nxt_o = div_q ? div_nxt : mul_nxt;
  end

  always_comb begin
    acc_d = acc_q;
    opd_d = opd_q;
    div_d = div_q;
    if (load_i) begin
      div_d = is_div_i;
      acc_d = {{WIDTH{1'b0}}, (is_div_i ? opa_i : opb_i)};
      opd_d = is_div_i ? opb_i : opa_i;
    end else if (step_i) begin
      acc_d = acc_nxt_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      opd_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opd_q <= opd_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL/MULH/DIV/REM execute stage with registered register-file writeback.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REG_ID_W = 3,
  parameter int CNT_W    = 5
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [1:0]          OP,
  input  logic [WIDTH-1:0]    OPA,
  input  logic [WIDTH-1:0]    OPB,
  input  logic [REG_ID_W-1:0] DST_ID,
  output logic                BUSY,
  output logic                DONE,
  output logic                DIV_ZERO,
  output logic [REG_ID_W-1:0] REG_W_ID,
  output logic                Reg_WE,
  output logic [WIDTH-1:0]    Reg_WData
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  op_e                 op_q, op_d;
  logic [REG_ID_W-1:0] dst_q, dst_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                divz_q, divz_d;
  logic [REG_ID_W-1:0] wid_q, wid_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic                dp_load, dp_step;
  logic [2*WIDTH-1:0]  acc_nxt;

  mdu_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .is_div_i (OP[1]),
    .opa_i    (OPA),
    .opb_i    (OPB),
    .acc_nxt_o(acc_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dst_d   = dst_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    divz_d  = divz_q;
    wid_d   = wid_q;
    wdata_d = wdata_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    unique case (state_q)
      S_IDLE: if (START) begin
        op_d    = op_e'(OP);
        dst_d   = DST_ID;
        dp_load = 1'b1;
        if (OP[1] && (OPB == '0)) begin
          // Divide by zero skips iteration and writes back next cycle.
          state_d = S_WB;
          we_d    = 1'b1;
          done_d  = 1'b1;
          wid_d   = DST_ID;
          wdata_d = OP[0] ? OPA : DIV0_QUOT[WIDTH-1:0];
          divz_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      S_RUN: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // Result is taken from the final step's next value so WB lands on the following cycle.
          state_d = S_WB;
          we_d    = 1'b1;
          done_d  = 1'b1;
          wid_d   = dst_q;
          if (op_q == OP_DIV || op_q == OP_REM) divz_d = 1'b0;
          case (op_q)
            OP_MUL:  wdata_d = acc_nxt[WIDTH-1:0];
            OP_MULH: wdata_d = acc_nxt[2*WIDTH-1:WIDTH];
            OP_DIV:  wdata_d = acc_nxt[WIDTH-1:0];
            OP_REM:  wdata_d = acc_nxt[2*WIDTH-1:WIDTH];
            default: wdata_d = '0;
          endcase
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      dst_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      wid_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      we_q    <= we_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
      wid_q   <= wid_d;
      wdata_q <= wdata_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign Reg_WE    = we_q;
  assign DIV_ZERO  = divz_q;
  assign REG_W_ID  = wid_q;
  assign Reg_WData = wdata_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes reference results, monitor checks each writeback.
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic [15:0] OPA = '0;
  logic [15:0] OPB = '0;
  logic [2:0]  DST_ID = '0;
  logic        BUSY, DONE, DIV_ZERO, Reg_WE;
  logic [2:0]  REG_W_ID;
  logic [15:0] Reg_WData;

  mul_div_unit dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
    .DST_ID(DST_ID), .BUSY(BUSY), .DONE(DONE), .DIV_ZERO(DIV_ZERO),
    .REG_W_ID(REG_W_ID), .Reg_WE(Reg_WE), .Reg_WData(Reg_WData)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] data;
    logic        dz;
    int unsigned wcyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic dz_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (op)
      2'b00:   ref_res = p[15:0];
      2'b01:   ref_res = p[31:16];
      2'b10:   ref_res = (b == 0) ? 16'hFFFF : a / b;
      default: ref_res = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every writeback must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST_N && (Reg_WE || DONE)) begin
      check("done_eq_we", {31'b0, DONE}, {31'b0, Reg_WE});
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_wb: got id %0d data %0h expected no writeback (cycle %0d)",
                 REG_W_ID, Reg_WData, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("wb_id",    {29'b0, REG_W_ID}, {29'b0, e.id});
        check("wb_data",  {16'b0, Reg_WData}, {16'b0, e.data});
        check("wb_dz",    {31'b0, DIV_ZERO}, {31'b0, e.dz});
        check("wb_cycle", cyc, e.wcyc);
      end
    end
  end

  // Called at a negedge; returns 1ns after the accepting posedge.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] id, input bit track);
    exp_t e;
    OP = op; OPA = a; OPB = b; DST_ID = id; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    if (track) begin
      if (op[1]) dz_model = (b == 0);
      e.id   = id;
      e.data = ref_res(op, a, b);
      e.dz   = dz_model;
      e.wcyc = (op[1] && b == 0) ? cyc : cyc + 16;
      sbq.push_back(e);
    end
  endtask

  // Waits for BUSY to drop while scrambling the operand inputs; returns at a negedge.
  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    check("busy_after_start", {31'b0, BUSY}, 32'd1);
    while (BUSY && n < 60) begin
      OPA = 16'($urandom); OPB = 16'($urandom); DST_ID = 3'($urandom); OP = 2'($urandom);
      @(negedge CLK);
      n++;
    end
    if (BUSY) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got BUSY=1 expected 0 within 60 cycles");
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  {31'b0, BUSY}, 32'd0);
    check({tag, "_done"},  {31'b0, DONE}, 32'd0);
    check({tag, "_we"},    {31'b0, Reg_WE}, 32'd0);
    check({tag, "_divz"},  {31'b0, DIV_ZERO}, 32'd0);
    check({tag, "_wid"},   {29'b0, REG_W_ID}, 32'd0);
    check({tag, "_wdata"}, {16'b0, Reg_WData}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [15:0] ra, rb;
    repeat (2) @(negedge CLK);
    check_zero_outputs("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    issue(2'b00, 16'd300, 16'd200, 3'd2, 1'b1);      wait_idle();
    issue(2'b01, 16'd300, 16'd200, 3'd2, 1'b1);      wait_idle();
    issue(2'b01, 16'h1234, 16'h5678, 3'd5, 1'b1);    wait_idle();
    issue(2'b00, 16'h1234, 16'h5678, 3'd5, 1'b1);    wait_idle();
    issue(2'b10, 16'd1000, 16'd7, 3'd1, 1'b1);       wait_idle();
    issue(2'b11, 16'd1000, 16'd7, 3'd1, 1'b1);       wait_idle();
    issue(2'b10, 16'h1234, 16'h0000, 3'd3, 1'b1);    wait_idle();
    issue(2'b00, 16'd5, 16'd6, 3'd6, 1'b1);          wait_idle();
    issue(2'b11, 16'h1234, 16'h0000, 3'd4, 1'b1);    wait_idle();
    issue(2'b10, 16'd10, 16'd3, 3'd7, 1'b1);         wait_idle();
    issue(2'b01, 16'hFFFF, 16'hFFFF, 3'd0, 1'b1);    wait_idle();
    issue(2'b10, 16'hFFFF, 16'd1, 3'd1, 1'b1);       wait_idle();
    issue(2'b11, 16'd3, 16'hFFFF, 3'd2, 1'b1);       wait_idle();

    // A START while busy must be dropped; the next one right after WB is accepted.
    issue(2'b00, 16'd300, 16'd200, 3'd3, 1'b1);
    repeat (4) @(negedge CLK);
    OP = 2'b10; OPA = 16'd9; OPB = 16'd9; DST_ID = 3'd6; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    wait_idle();
    issue(2'b10, 16'd1000, 16'd7, 3'd4, 1'b1);       wait_idle();

    // Reset mid-run: no writeback may appear for the aborted operation.
    issue(2'b10, 16'd1000, 16'd7, 3'd4, 1'b0);
    repeat (7) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_zero_outputs("midrst");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    dz_model = 1'b0;
    @(negedge CLK);
    check("post_rst_busy", {31'b0, BUSY}, 32'd0);
    repeat (20) @(negedge CLK);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      issue(rop, ra, rb, 3'($urandom), 1'b1);
      wait_idle();
    end

    repeat (3) @(negedge CLK);
    check("sb_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
